// File: rtl/ula_cmd_master.sv
// Command master that sequences an optional ULA register write, then an operation, and returns one response.
// Define ULA_CMD_MASTER_TIMEOUT_EN to bound the wait for valid_out by TIMEOUT_CYC cycles.
module ula_cmd_master #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk_ula,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr_en,
  input  logic [1:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic [15:0] cmd_a,
  input  logic [1:0]  cmd_reg_sel,
  input  logic [1:0]  cmd_instru,
  output logic [15:0] A,
  output logic [1:0]  reg_sel,
  output logic [1:0]  instru,
  output logic        valid_ula,
  output logic [15:0] data_in,
  output logic [1:0]  addr,
  output logic        valid_reg,
  input  logic [31:0] data_out,
  input  logic        valid_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic [7:0]  stray_cnt
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_timeout_range
    $error("TIMEOUT_CYC must be in 2..255");
  end

  typedef enum logic [2:0] {IDLE, WREG, OP, WAIT, RSP} state_t;

  state_t      state_q;
  logic        cmd_ready_q, valid_reg_q, valid_ula_q, rsp_valid_q;
  logic [15:0] a_q, data_in_q, lat_a_q;
  logic [1:0]  reg_sel_q, instru_q, addr_q, lat_reg_sel_q, lat_instru_q;
  logic [31:0] rsp_data_q;
  logic [7:0]  stray_q;

`ifdef ULA_CMD_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] to_cnt_q;
  logic       rsp_timeout_q;
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk_ula) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b1;
      valid_reg_q   <= 1'b0;
      valid_ula_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      a_q           <= '0;
      reg_sel_q     <= '0;
      instru_q      <= '0;
      data_in_q     <= '0;
      addr_q        <= '0;
      lat_a_q       <= '0;
      lat_reg_sel_q <= '0;
      lat_instru_q  <= '0;
      rsp_data_q    <= '0;
      stray_q       <= '0;
`ifdef ULA_CMD_MASTER_TIMEOUT_EN
      to_cnt_q      <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      // Only WAIT consumes valid_out; anything else is counted, never captured.
      if (valid_out && state_q != WAIT && stray_q != '1)
        stray_q <= stray_q + 8'd1;

      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q   <= 1'b0;
            lat_a_q       <= cmd_a;
            lat_reg_sel_q <= cmd_reg_sel;
            lat_instru_q  <= cmd_instru;
            if (cmd_wr_en) begin
              addr_q      <= cmd_addr;
              data_in_q   <= cmd_data;
              valid_reg_q <= 1'b1;
              state_q     <= WREG;
            end else begin
              a_q         <= cmd_a;
              reg_sel_q   <= cmd_reg_sel;
              instru_q    <= cmd_instru;
              valid_ula_q <= 1'b1;
              state_q     <= OP;
            end
          end
        end
        WREG: begin
          valid_reg_q <= 1'b0;
          a_q         <= lat_a_q;
          reg_sel_q   <= lat_reg_sel_q;
          instru_q    <= lat_instru_q;
          valid_ula_q <= 1'b1;
          state_q     <= OP;
        end
        OP: begin
          valid_ula_q <= 1'b0;
          state_q     <= WAIT;
`ifdef ULA_CMD_MASTER_TIMEOUT_EN
          to_cnt_q    <= '0;
`endif
        end
        WAIT: begin
          if (valid_out) begin
            rsp_data_q    <= data_out;
            rsp_valid_q   <= 1'b1;
            state_q       <= RSP;
`ifdef ULA_CMD_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
          end else if (to_cnt_q == TO_LAST) begin
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= RSP;
          end else begin
            to_cnt_q      <= to_cnt_q + 8'd1;
`endif
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign valid_reg = valid_reg_q;
  assign valid_ula = valid_ula_q;
  assign A         = a_q;
  assign reg_sel   = reg_sel_q;
  assign instru    = instru_q;
  assign data_in   = data_in_q;
  assign addr      = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign stray_cnt = stray_q;

endmodule

// File: tb/tb_ula_cmd_master.sv
// Self-checking bench for ula_cmd_master: timestamp-based transaction model plus directed literal checks.
module tb_ula_cmd_master;
  localparam int TO = 16;
`ifdef ULA_CMD_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cmd_valid, cmd_ready, cmd_wr_en;
  logic [1:0]  cmd_addr, cmd_reg_sel, cmd_instru, reg_sel, instru, addr;
  logic [15:0] cmd_data, cmd_a, A, data_in;
  logic        valid_ula, valid_reg, valid_out, rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] data_out, rsp_data;
  logic [7:0]  stray_cnt;

  ula_cmd_master #(.TIMEOUT_CYC(TO)) dut (
    .clk_ula(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_en(cmd_wr_en),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_a(cmd_a),
    .cmd_reg_sel(cmd_reg_sel), .cmd_instru(cmd_instru),
    .A(A), .reg_sel(reg_sel), .instru(instru), .valid_ula(valid_ula),
    .data_in(data_in), .addr(addr), .valid_reg(valid_reg),
    .data_out(data_out), .valid_out(valid_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .stray_cnt(stray_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: one outstanding command described by its acceptance cycle and response cycle.
  bit          m_known = 1'b0;
  bit          m_out, m_wr, m_dec, m_rto;
  int          m_acc, m_rcyc, m_stray;
  logic [31:0] m_rdata;
  logic [15:0] l_a, h_a, h_din;
  logic [1:0]  l_rs, l_ins, h_rs, h_ins, h_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_model();
    bit e_vreg, e_vula, e_rv;
    if (!m_known) return;
    e_vreg = m_out && m_wr && (cyc == m_acc + 1);
    e_vula = m_out && (cyc == m_acc + 1 + int'(m_wr));
    e_rv   = m_out && m_dec && (cyc >= m_rcyc);
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_out));
    chk("valid_reg", 32'(valid_reg), 32'(e_vreg));
    chk("valid_ula", 32'(valid_ula), 32'(e_vula));
    chk("A", 32'(A), 32'(h_a));
    chk("reg_sel", 32'(reg_sel), 32'(h_rs));
    chk("instru", 32'(instru), 32'(h_ins));
    chk("data_in", 32'(data_in), 32'(h_din));
    chk("addr", 32'(addr), 32'(h_addr));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("stray_cnt", 32'(stray_cnt), 32'(m_stray));
    if (e_rv) begin
      chk("rsp_data", rsp_data, m_rdata);
      chk("rsp_timeout", 32'(rsp_timeout), 32'(m_rto));
    end
  endtask

  task automatic model_advance();
    bit in_wait;
    int wait_start;
    if (rst) begin
      m_known = 1'b1; m_out = 1'b0; m_dec = 1'b0; m_stray = 0;
      h_a = '0; h_rs = '0; h_ins = '0; h_din = '0; h_addr = '0;
      m_rdata = '0; m_rto = 1'b0;
      return;
    end
    if (!m_known) return;
    wait_start = m_acc + 2 + int'(m_wr);
    in_wait = m_out && !m_dec && (cyc >= wait_start);
    if (valid_out && !in_wait && m_stray < 255) m_stray++;
    if (!m_out) begin
      if (cmd_valid) begin
        m_out = 1'b1; m_acc = cyc; m_wr = cmd_wr_en; m_dec = 1'b0;
        l_a = cmd_a; l_rs = cmd_reg_sel; l_ins = cmd_instru;
        if (cmd_wr_en) begin
          h_addr = cmd_addr; h_din = cmd_data;
        end else begin
          h_a = cmd_a; h_rs = cmd_reg_sel; h_ins = cmd_instru;
        end
      end
    end else begin
      if (m_wr && cyc == m_acc + 1) begin
        h_a = l_a; h_rs = l_rs; h_ins = l_ins;
      end
      if (in_wait) begin
        if (valid_out) begin
          m_dec = 1'b1; m_rcyc = cyc + 1; m_rdata = data_out; m_rto = 1'b0;
        end else if (TO_EN && (cyc - wait_start + 1 == TO)) begin
          m_dec = 1'b1; m_rcyc = cyc + 1; m_rdata = '0; m_rto = 1'b1;
        end
      end else if (m_dec && cyc >= m_rcyc && rsp_ready) begin
        m_out = 1'b0;
      end
    end
  endtask

  task automatic step();
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
    check_model();
  endtask

  task automatic quiet();
    rst = 1'b0; cmd_valid = 1'b0; cmd_wr_en = 1'b0; cmd_addr = '0; cmd_data = '0;
    cmd_a = '0; cmd_reg_sel = '0; cmd_instru = '0; valid_out = 1'b0;
    data_out = '0; rsp_ready = 1'b0;
  endtask

  initial begin
    int k;
    int resp_at;
    int dly;
    quiet();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_stray", 32'(stray_cnt), 32'd0);

    // Write then operate; ULA answers three cycles after valid_ula.
    cmd_valid = 1'b1; cmd_wr_en = 1'b1; cmd_addr = 2'd2; cmd_data = 16'h00FF;
    cmd_a = 16'h0101; cmd_reg_sel = 2'd2; cmd_instru = 2'd1;
    step();
    cmd_valid = 1'b0;
    chk("wr_vreg_n1", 32'(valid_reg), 32'd1);
    chk("wr_vula_n1", 32'(valid_ula), 32'd0);
    chk("wr_addr", 32'(addr), 32'd2);
    chk("wr_data_in", 32'(data_in), 32'h00FF);
    step();
    chk("wr_vula_n2", 32'(valid_ula), 32'd1);
    chk("wr_vreg_n2", 32'(valid_reg), 32'd0);
    chk("wr_A", 32'(A), 32'h0101);
    chk("wr_reg_sel", 32'(reg_sel), 32'd2);
    chk("wr_instru", 32'(instru), 32'd1);
    step(); step(); step();
    valid_out = 1'b1; data_out = 32'h0000_0200;
    step();
    valid_out = 1'b0;
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_data", rsp_data, 32'h0000_0200);
    chk("wr_rsp_timeout", 32'(rsp_timeout), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("wr_retire_rv", 32'(rsp_valid), 32'd0);
    chk("wr_retire_ready", 32'(cmd_ready), 32'd1);

    // Operate only; response one cycle after valid_ula, then a held-off consumer.
    cmd_valid = 1'b1; cmd_wr_en = 1'b0; cmd_a = 16'hFFFF; cmd_reg_sel = 2'd0; cmd_instru = 2'd3;
    step();
    cmd_valid = 1'b0;
    chk("op_vula_n1", 32'(valid_ula), 32'd1);
    chk("op_vreg_n1", 32'(valid_reg), 32'd0);
    chk("op_A", 32'(A), 32'hFFFF);
    chk("op_instru", 32'(instru), 32'd3);
    step();
    valid_out = 1'b1; data_out = 32'hDEAD_BEEF;
    step();
    valid_out = 1'b0;
    chk("op_rsp_data", rsp_data, 32'hDEAD_BEEF);
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_data", rsp_data, 32'hDEAD_BEEF);
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("retire_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("retire_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    cmd_valid = 1'b0;
    chk("accept_next_cycle", 32'(cmd_ready), 32'd0);
    step();
    valid_out = 1'b1; data_out = 32'h0000_1234;
    step();
    valid_out = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Stray saturation and clear on reset.
    valid_out = 1'b1;
    for (int i = 0; i < 300; i++) step();
    valid_out = 1'b0;
    chk("stray_saturate", 32'(stray_cnt), 32'd255);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("stray_cleared", 32'(stray_cnt), 32'd0);

    // Reset while waiting abandons the command.
    cmd_valid = 1'b1; cmd_wr_en = 1'b0;
    step();
    cmd_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("wait_rst_ready", 32'(cmd_ready), 32'd1);
    chk("wait_rst_rv", 32'(rsp_valid), 32'd0);
    valid_out = 1'b1;
    step();
    valid_out = 1'b0;
    chk("wait_rst_stray", 32'(stray_cnt), 32'd1);
    for (int i = 0; i < 4; i++) step();

    if (TO_EN) begin
      cmd_valid = 1'b1; cmd_wr_en = 1'b0;
      step();
      cmd_valid = 1'b0;
      k = 0;
      while (!rsp_valid && k < 40) begin
        step();
        k++;
      end
      chk("timeout_latency", 32'(k), 32'(TO + 1));
      chk("timeout_flag", 32'(rsp_timeout), 32'd1);
      chk("timeout_data", rsp_data, 32'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end

    // Randomized traffic against the model.
    resp_at = -1;
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      cmd_valid   = ($urandom_range(0, 2) == 0);
      cmd_wr_en   = 1'($urandom_range(0, 1));
      cmd_addr    = 2'($urandom);
      cmd_data    = 16'($urandom);
      cmd_a       = 16'($urandom);
      cmd_reg_sel = 2'($urandom);
      cmd_instru  = 2'($urandom);
      rsp_ready   = ($urandom_range(0, 2) != 0);
      if (m_out && cyc == m_acc + 1 + int'(m_wr)) begin
        if (TO_EN) begin
          k = $urandom_range(0, 9);
          dly = (k < 6) ? 1 + k : (k < 8) ? TO : TO + 5;
        end else begin
          dly = $urandom_range(1, 6);
        end
        resp_at = cyc + dly;
      end
      valid_out = (cyc == resp_at) || ($urandom_range(0, 11) == 0);
      data_out  = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
